// File: rtl/bottling_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bottling_sequencer_pkg
//  Description : Shared types and default constants for the bottling
//                sequencer (controller state, sequencer sub-state, error code).
//  Revision    : 1.0 - initial release
// ============================================================================
package bottling_sequencer_pkg;

  // Default parameter values for the sequencer and its timers
  localparam int unsigned DEF_PILL_W         = 6;
  localparam int unsigned DEF_BOTTLE_W       = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
  localparam int unsigned DEF_ADVANCE_CYCLES = 50;

  // Top-level controller state driven by state_machine
  typedef enum logic [2:0] {
    setting_state = 3'd0,
    working_state = 3'd1,
    pause_state   = 3'd2,
    error_state   = 3'd3,
    final_state   = 3'd4
  } state_t;

  // Sequencer sub-state
  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_FILL    = 3'd1,
    SEQ_ADVANCE = 3'd2,
    SEQ_DONE    = 3'd3,
    SEQ_FAULT   = 3'd4
  } seq_state_t;

  // Fault reason reported alongside error_signal
  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_TIMEOUT    = 2'd1,
    ERR_OVERFLOW   = 2'd2,
    ERR_BAD_CONFIG = 2'd3
  } seq_err_t;

  // Timer width able to hold (cycles - 1), never narrower than one bit
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bottling_sequencer_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bottling_sequencer_cycle_timer
//  Description : Down-counting cycle timer. load presets the count, enable
//                decrements it (hold when low), expired flags a zero count.
//  Revision    : 1.0 - initial release
// ============================================================================
module bottling_sequencer_cycle_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Count register: clear beats load, load beats decrement; stops at zero
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/bottling_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bottling_sequencer
//  Description : Pill-feed / conveyor sequencer active while the controller
//                is working. Counts pills per bottle, advances the conveyor,
//                counts bottles and reports completion or fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module bottling_sequencer
  import bottling_sequencer_pkg::*;
#(
  parameter int unsigned PILL_W         = DEF_PILL_W,
  parameter int unsigned BOTTLE_W       = DEF_BOTTLE_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ADVANCE_CYCLES = DEF_ADVANCE_CYCLES
) (
  input  logic                clock,
  input  logic                reset_n,
  input  state_t              state,
  input  logic                pill_pulse,
  input  logic [PILL_W-1:0]   pills_per_bottle,
  input  logic [BOTTLE_W-1:0] bottle_target,
  output logic                feeder_enable,
  output logic                conveyor_advance,
  output logic [PILL_W-1:0]   pill_count,
  output logic [BOTTLE_W-1:0] bottle_count,
  output logic                complete_signal,
  output logic                error_signal,
  output seq_err_t            error_code
);

  // Timers are loaded with (cycles - 1) so that a fault / conveyor stop lands
  // exactly on the N-th counted cycle.
  localparam int unsigned TO_W = timer_width(TIMEOUT_CYCLES);
  localparam int unsigned AD_W = timer_width(ADVANCE_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AD_W-1:0] AD_LOAD = AD_W'(ADVANCE_CYCLES - 1);

  seq_state_t          seq, seq_next;
  logic [PILL_W-1:0]   ppb_latched, ppb_next;
  logic [BOTTLE_W-1:0] target_latched, target_next;
  logic [PILL_W-1:0]   pills_next;
  logic [BOTTLE_W-1:0] bottles_next;
  seq_err_t            err_next;
  logic                feeder_next, conveyor_next, complete_next, error_next;

  logic is_working, is_pause, is_hold, is_setting;
  logic timers_clear;
  logic to_load, to_enable, to_expired;
  logic ad_load, ad_enable, ad_expired;

  // Controller state decode; anything unrecognised behaves as setting_state
  always_comb begin
    is_working = 1'b0;
    is_pause   = 1'b0;
    is_hold    = 1'b0;
    case (state)
      working_state:            is_working = 1'b1;
      pause_state:              is_pause   = 1'b1;
      error_state, final_state: is_hold    = 1'b1;
      default:                  ;
    endcase
    is_setting = !(is_working || is_pause || is_hold);
  end

  bottling_sequencer_cycle_timer #(.WIDTH(TO_W)) u_timeout_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (timers_clear),
    .load       (to_load),
    .load_value (TO_LOAD),
    .enable     (to_enable),
    .expired    (to_expired)
  );

  bottling_sequencer_cycle_timer #(.WIDTH(AD_W)) u_advance_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (timers_clear),
    .load       (ad_load),
    .load_value (AD_LOAD),
    .enable     (ad_enable),
    .expired    (ad_expired)
  );

  // Sub-FSM next state, counter/config updates, timer controls and next outputs
  always_comb begin
    seq_next      = seq;
    ppb_next      = ppb_latched;
    target_next   = target_latched;
    pills_next    = pill_count;
    bottles_next  = bottle_count;
    err_next      = error_code;
    timers_clear  = 1'b0;
    to_load       = 1'b0;
    to_enable     = 1'b0;
    ad_load       = 1'b0;
    ad_enable     = 1'b0;

    if (is_setting) begin
      seq_next     = SEQ_IDLE;
      ppb_next     = '0;
      target_next  = '0;
      pills_next   = '0;
      bottles_next = '0;
      err_next     = ERR_NONE;
      timers_clear = 1'b1;
    end else begin
      case (seq)
        SEQ_IDLE: begin
          if (is_working) begin
            ppb_next    = pills_per_bottle;
            target_next = bottle_target;
            if ((pills_per_bottle == '0) || (bottle_target == '0)) begin
              seq_next = SEQ_FAULT;
              err_next = ERR_BAD_CONFIG;
            end else begin
              seq_next = SEQ_FILL;
              to_load  = 1'b1;
            end
          end
        end

        SEQ_FILL: begin
          if (is_working || is_pause) begin
            if (pill_pulse) begin
              // A pill beyond a full bottle cannot be counted
              if (pill_count == ppb_latched) begin
                seq_next = SEQ_FAULT;
                err_next = ERR_OVERFLOW;
              end else begin
                pills_next = pill_count + 1'b1;
                to_load    = 1'b1;
                if (is_working && (pills_next == ppb_latched)) begin
                  seq_next = SEQ_ADVANCE;
                  ad_load  = 1'b1;
                end
              end
            end else if (is_working) begin
              // Bottle filled by coasting pills during a pause
              if (pill_count == ppb_latched) begin
                seq_next = SEQ_ADVANCE;
                ad_load  = 1'b1;
              end else if (to_expired) begin
                seq_next = SEQ_FAULT;
                err_next = ERR_TIMEOUT;
              end else begin
                to_enable = 1'b1;
              end
            end
          end
        end

        SEQ_ADVANCE: begin
          if (is_working || is_pause) begin
            if (pill_pulse) begin
              seq_next = SEQ_FAULT;
              err_next = ERR_OVERFLOW;
            end else if (is_working) begin
              if (ad_expired) begin
                bottles_next = bottle_count + 1'b1;
                pills_next   = '0;
                if (bottles_next == target_latched) begin
                  seq_next = SEQ_DONE;
                end else begin
                  seq_next = SEQ_FILL;
                  to_load  = 1'b1;
                end
              end else begin
                ad_enable = 1'b1;
              end
            end
          end
        end

        default: ;
      endcase
    end

    feeder_next   = is_working && (seq_next == SEQ_FILL);
    conveyor_next = is_working && (seq_next == SEQ_ADVANCE);
    complete_next = (seq_next == SEQ_DONE);
    error_next    = (seq_next == SEQ_FAULT);
  end

  // Sub-state, latched configuration and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seq              <= SEQ_IDLE;
      ppb_latched      <= '0;
      target_latched   <= '0;
      pill_count       <= '0;
      bottle_count     <= '0;
      feeder_enable    <= 1'b0;
      conveyor_advance <= 1'b0;
      complete_signal  <= 1'b0;
      error_signal     <= 1'b0;
      error_code       <= ERR_NONE;
    end else begin
      seq              <= seq_next;
      ppb_latched      <= ppb_next;
      target_latched   <= target_next;
      pill_count       <= pills_next;
      bottle_count     <= bottles_next;
      feeder_enable    <= feeder_next;
      conveyor_advance <= conveyor_next;
      complete_signal  <= complete_next;
      error_signal     <= error_next;
      error_code       <= err_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bottling_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bottling_sequencer
//  Description : Self-checking bench for bottling_sequencer with a
//                behavioural reference model run in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bottling_sequencer;
  import bottling_sequencer_pkg::*;

  localparam int TIMEOUT_CYCLES = 1000;
  localparam int ADVANCE_CYCLES = 50;

  logic       clock = 1'b0;
  logic       reset_n;
  state_t     state;
  logic       pill_pulse;
  logic [5:0] pills_per_bottle;
  logic [7:0] bottle_target;
  logic       feeder_enable, conveyor_advance, complete_signal, error_signal;
  logic [5:0] pill_count;
  logic [7:0] bottle_count;
  seq_err_t   error_code;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  bottling_sequencer #(
    .PILL_W(6), .BOTTLE_W(8),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ADVANCE_CYCLES(ADVANCE_CYCLES)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .state            (state),
    .pill_pulse       (pill_pulse),
    .pills_per_bottle (pills_per_bottle),
    .bottle_target    (bottle_target),
    .feeder_enable    (feeder_enable),
    .conveyor_advance (conveyor_advance),
    .pill_count       (pill_count),
    .bottle_count     (bottle_count),
    .complete_signal  (complete_signal),
    .error_signal     (error_signal),
    .error_code       (error_code)
  );

  wire [19:0] obs = {feeder_enable, conveyor_advance, pill_count, bottle_count,
                     complete_signal, error_signal, error_code};

  // ---------------- reference model (batch phases, counting up) -------------
  localparam int PH_IDLE = 0, PH_FILL = 1, PH_ADV = 2, PH_DONE = 3, PH_FAULT = 4;
  int m_phase = PH_IDLE, m_pills = 0, m_bottles = 0, m_ppb = 0, m_target = 0;
  int m_quiet = 0, m_adv = 0, m_code = 0;
  bit m_feed = 0, m_conv = 0;

  function automatic void model_fault(input int code);
    m_phase = PH_FAULT;
    m_code  = code;
  endfunction

  function automatic void model_edge(input logic rn, input state_t st, input logic pulse);
    bit wk = (st == working_state);
    bit ps = (st == pause_state);
    bit hd = (st == error_state) || (st == final_state);
    if (!rn || !(wk || ps || hd)) begin
      m_phase = PH_IDLE; m_pills = 0; m_bottles = 0; m_ppb = 0; m_target = 0;
      m_quiet = 0; m_adv = 0; m_code = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (wk) begin
          m_ppb = int'(pills_per_bottle);
          m_target = int'(bottle_target);
          if (m_ppb == 0 || m_target == 0) model_fault(3);
          else begin m_phase = PH_FILL; m_quiet = 0; end
        end
        PH_FILL: if (wk || ps) begin
          if (pulse) begin
            if (m_pills == m_ppb) model_fault(2);
            else begin
              m_pills++;
              m_quiet = 0;
              if (wk && m_pills == m_ppb) begin m_phase = PH_ADV; m_adv = 1; end
            end
          end else if (wk) begin
            if (m_pills == m_ppb) begin m_phase = PH_ADV; m_adv = 1; end
            else begin
              m_quiet++;
              if (m_quiet >= TIMEOUT_CYCLES) model_fault(1);
            end
          end
        end
        PH_ADV: if (wk || ps) begin
          if (pulse) model_fault(2);
          else if (wk) begin
            if (m_adv == ADVANCE_CYCLES) begin
              m_bottles++;
              m_pills = 0;
              if (m_bottles == m_target) m_phase = PH_DONE;
              else begin m_phase = PH_FILL; m_quiet = 0; end
            end else m_adv++;
          end
        end
        default: ;
      endcase
    end
    m_feed = rn && wk && (m_phase == PH_FILL);
    m_conv = rn && wk && (m_phase == PH_ADV);
  endfunction

  function automatic logic [19:0] exp_vec();
    return {m_feed, m_conv, 6'(m_pills), 8'(m_bottles),
            (m_phase == PH_DONE), (m_phase == PH_FAULT), 2'(m_code)};
  endfunction

  // One clock: apply inputs, let DUT and model see the same edge, settle
  task automatic step(input state_t st, input logic pulse);
    state = st;
    pill_pulse = pulse;
    @(posedge clock);
    model_edge(reset_n, st, pulse);
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset_n = 1'b0;
    pills_per_bottle = 6'd3;
    bottle_target = 8'd2;
    for (int i = 0; i < 3; i++) begin
      step(working_state, 1'b1);
      checks++;
      if (obs !== 20'd0) begin
        fails++;
        $display("FAIL reset_outputs: actual=%h required=%h", obs, 20'd0);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_normal_batch();
    int conv_cycles = 0;
    pills_per_bottle = 6'd3;
    bottle_target = 8'd2;
    step(setting_state, 1'b0);
    step(working_state, 1'b0);
    checks++;
    if (feeder_enable !== 1'b1) begin
      fails++; $display("FAIL normal_feeder_on: actual=%b required=1", feeder_enable);
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 6 + 60; i++) begin
        step(working_state, (i < 6) && ((i % 2) == 0));
        if (conveyor_advance) conv_cycles++;
        checks++;
        if (obs !== exp_vec()) begin
          fails++; $display("FAIL normal_lockstep @%0t: actual=%h required=%h", $time, obs, exp_vec());
        end
      end
    end
    checks++;
    if (conv_cycles != 2 * ADVANCE_CYCLES) begin
      fails++; $display("FAIL normal_conveyor_cycles: actual=%0d required=%0d", conv_cycles, 2 * ADVANCE_CYCLES);
    end
    checks++;
    if ({bottle_count, complete_signal, feeder_enable, error_signal} !== {8'd2, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL normal_done: actual bottles=%0d complete=%b feeder=%b error=%b required 2/1/0/0",
                        bottle_count, complete_signal, feeder_enable, error_signal);
    end
  endtask

  task automatic test_timeout(input bit rescue);
    pills_per_bottle = 6'd5;
    bottle_target = 8'd3;
    step(setting_state, 1'b0);
    step(working_state, 1'b0);
    step(working_state, 1'b1);
    step(working_state, 1'b0);
    step(working_state, 1'b1);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
      step(working_state, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL timeout_lockstep @%0t: actual=%h required=%h", $time, obs, exp_vec());
      end
    end
    checks++;
    if (error_signal !== 1'b0) begin
      fails++; $display("FAIL timeout_early: actual error=%b required=0", error_signal);
    end
    step(working_state, rescue);
    checks++;
    if (rescue) begin
      if ({error_signal, error_code, pill_count} !== {1'b0, ERR_NONE, 6'd3}) begin
        fails++; $display("FAIL timeout_rescue: actual err=%b code=%0d pills=%0d required 0/0/3",
                          error_signal, error_code, pill_count);
      end
    end else begin
      if ({error_signal, error_code, pill_count, feeder_enable} !== {1'b1, ERR_TIMEOUT, 6'd2, 1'b0}) begin
        fails++; $display("FAIL timeout_fault: actual err=%b code=%0d pills=%0d feeder=%b required 1/1/2/0",
                          error_signal, error_code, pill_count, feeder_enable);
      end
    end
  endtask

  task automatic test_pause();
    int feeder_seen = 0;
    pills_per_bottle = 6'd4;
    bottle_target = 8'd1;
    step(setting_state, 1'b0);
    step(working_state, 1'b0);
    step(working_state, 1'b1);
    step(working_state, 1'b0);
    step(working_state, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      step(pause_state, i == 2500);
      if (feeder_enable || error_signal) feeder_seen++;
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL pause_lockstep @%0t: actual=%h required=%h", $time, obs, exp_vec());
      end
    end
    checks++;
    if ({feeder_seen, pill_count} !== {32'd0, 6'd3}) begin
      fails++; $display("FAIL pause_hold: actual feeder/err cycles=%0d pills=%0d required 0/3", feeder_seen, pill_count);
    end
    step(working_state, 1'b0);
    checks++;
    if (feeder_enable !== 1'b1) begin
      fails++; $display("FAIL pause_resume_feeder: actual=%b required=1", feeder_enable);
    end
    for (int i = 0; i < ADVANCE_CYCLES + 5; i++) begin
      step(working_state, i == 0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL pause_resume_lockstep @%0t: actual=%h required=%h", $time, obs, exp_vec());
      end
    end
    checks++;
    if ({complete_signal, bottle_count, pill_count} !== {1'b1, 8'd1, 6'd0}) begin
      fails++; $display("FAIL pause_complete: actual done=%b bottles=%0d pills=%0d required 1/1/0",
                        complete_signal, bottle_count, pill_count);
    end
  endtask

  task automatic test_overflow();
    pills_per_bottle = 6'd2;
    bottle_target = 8'd2;
    step(setting_state, 1'b0);
    step(working_state, 1'b0);
    step(working_state, 1'b1);
    step(working_state, 1'b0);
    step(working_state, 1'b1);
    for (int i = 0; i < 10; i++) step(working_state, 1'b0);
    checks++;
    if (conveyor_advance !== 1'b1) begin
      fails++; $display("FAIL overflow_conveyor_on: actual=%b required=1", conveyor_advance);
    end
    step(working_state, 1'b1);
    checks++;
    if ({error_signal, error_code, conveyor_advance, bottle_count, pill_count}
        !== {1'b1, ERR_OVERFLOW, 1'b0, 8'd0, 6'd2}) begin
      fails++; $display("FAIL overflow_fault: actual err=%b code=%0d conv=%b bottles=%0d pills=%0d required 1/2/0/0/2",
                        error_signal, error_code, conveyor_advance, bottle_count, pill_count);
    end
  endtask

  task automatic test_bad_config();
    logic [13:0] cfgs [3];
    cfgs[0] = {6'd0, 8'd3};
    cfgs[1] = {6'd4, 8'd0};
    cfgs[2] = {6'd0, 8'd0};
    for (int k = 0; k < 3; k++) begin
      {pills_per_bottle, bottle_target} = cfgs[k];
      step(setting_state, 1'b0);
      step(working_state, 1'b0);
      checks++;
      if ({error_signal, error_code, feeder_enable, complete_signal} !== {1'b1, ERR_BAD_CONFIG, 1'b0, 1'b0}) begin
        fails++; $display("FAIL bad_config_%0d: actual err=%b code=%0d feeder=%b done=%b required 1/3/0/0",
                          k, error_signal, error_code, feeder_enable, complete_signal);
      end
    end
  endtask

  task automatic test_return_to_setting();
    step(setting_state, 1'b0);
    checks++;
    if (obs !== 20'd0) begin
      fails++; $display("FAIL setting_from_fault: actual=%h required=%h", obs, 20'd0);
    end
    pills_per_bottle = 6'd1;
    bottle_target = 8'd3;
    step(working_state, 1'b0);
    step(working_state, 1'b1);
    for (int i = 0; i < 7; i++) step(working_state, 1'b0);
    reset_n = 1'b0;
    step(working_state, 1'b0);
    checks++;
    if (obs !== 20'd0) begin
      fails++; $display("FAIL reset_mid_advance: actual=%h required=%h", obs, 20'd0);
    end
    reset_n = 1'b1;
    bottle_target = 8'd1;
    for (int i = 0; i < ADVANCE_CYCLES + 5; i++) begin
      step(working_state, i == 1);
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL fresh_batch_lockstep @%0t: actual=%h required=%h", $time, obs, exp_vec());
      end
    end
    checks++;
    if ({complete_signal, bottle_count} !== {1'b1, 8'd1}) begin
      fails++; $display("FAIL fresh_batch_done: actual done=%b bottles=%0d required 1/1", complete_signal, bottle_count);
    end
  endtask

  task automatic test_random();
    state_t st;
    int r;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 5) begin
        pills_per_bottle = 6'($urandom_range(0, 4));
        bottle_target = 8'($urandom_range(0, 3));
      end
      reset_n = ($urandom_range(0, 399) != 0);
      r = $urandom_range(0, 199);
      if (r < 150)      st = working_state;
      else if (r < 180) st = pause_state;
      else if (r < 188) st = error_state;
      else if (r < 194) st = final_state;
      else if (r < 197) st = setting_state;
      else              st = state_t'(3'(5 + $urandom_range(0, 2)));
      step(st, ($urandom_range(0, 11) == 0));
      checks++;
      if (obs !== exp_vec()) begin
        fails++; $display("FAIL random_lockstep @%0t: actual=%h required=%h", $time, obs, exp_vec());
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    state = setting_state;
    pill_pulse = 1'b0;
    pills_per_bottle = '0;
    bottle_target = '0;
    test_reset();
    test_normal_batch();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_pause();
    test_overflow();
    test_bad_config();
    test_return_to_setting();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
